out_feeder: RTL and testbench

- Sits directly upstream of the seven-segment output display stage.
- Drives that stage's outval1/outval2/outsel/outdisplay inputs.
- Accepts 16-bit OUT writes from the processor writeback into an 8-slot × 2-half shadow register file and tracks dirty slots.
- Replays dirty slots to the display one at a time, round-robin, rate-limited, so writing one half never clobbers the other.

---
 rtl/out_feeder.sv | 128 ++++++++++++
 tb/tb_out_feeder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/out_feeder.sv
`default_nettype none
// ============================================================================
// Module   : out_feeder
// Purpose  : Shadows 8x2 display words and replays dirty slots round-robin,
//            rate-limited, into the seven-segment output stage.
// Revision : 1.0 - initial release
// ============================================================================
module out_feeder #(
    parameter int HOLDOFF = 4,
    parameter int CNT_W   = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_slot,
    input  logic        wr_half,
    input  logic [15:0] wr_data,
    input  logic        clr,
    output logic [15:0] outval1,
    output logic [15:0] outval2,
    output logic [2:0]  outsel,
    output logic        outdisplay,
    output logic [7:0]  pending,
    output logic        busy
);

    localparam int c_SLOTS = 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    logic [15:0]      r_sh1 [c_SLOTS];
    logic [15:0]      r_sh2 [c_SLOTS];
    logic [7:0]       r_dirty;
    logic [2:0]       r_ptr;
    logic [CNT_W-1:0] r_cnt;

    state_t           w_state;
    logic             w_emit;
    logic [2:0]       w_sel;
    logic [2:0]       w_idx;
    logic             w_found;
    logic [7:0]       w_dirty_nxt;

    assign w_state = (r_cnt == '0) ? ST_IDLE : ST_HOLD;
    assign w_emit  = (w_state == ST_IDLE) && (r_dirty != 8'h00);

    // First dirty slot at or above the pointer, wrapping modulo 8.
    always_comb begin
        w_sel   = r_ptr;
        w_idx   = r_ptr;
        w_found = 1'b0;
        for (int i = 0; i < c_SLOTS; i++) begin
            w_idx = r_ptr + 3'(i);
            if (!w_found && r_dirty[w_idx]) begin
                w_sel   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    // A same-cycle write re-dirties the slot being emitted; clr overrides all.
    always_comb begin
        w_dirty_nxt = r_dirty;
        if (w_emit) begin
            w_dirty_nxt[w_sel] = 1'b0;
        end
        if (wr_en) begin
            w_dirty_nxt[wr_slot] = 1'b1;
        end
        if (clr) begin
            w_dirty_nxt = 8'hFF;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_SLOTS; i++) begin
                r_sh1[i] <= 16'h0000;
                r_sh2[i] <= 16'h0000;
            end
        end else if (clr) begin
            for (int i = 0; i < c_SLOTS; i++) begin
                r_sh1[i] <= 16'h0000;
                r_sh2[i] <= 16'h0000;
            end
        end else if (wr_en) begin
            if (wr_half) begin
                r_sh2[wr_slot] <= wr_data;
            end else begin
                r_sh1[wr_slot] <= wr_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dirty    <= 8'h00;
            r_ptr      <= 3'd0;
            r_cnt      <= '0;
            outval1    <= 16'h0000;
            outval2    <= 16'h0000;
            outsel     <= 3'd0;
            outdisplay <= 1'b0;
        end else begin
            r_dirty    <= w_dirty_nxt;
            outdisplay <= w_emit;
            if (w_state == ST_HOLD) begin
                r_cnt <= r_cnt - 1'b1;
            end else if (w_emit) begin
                r_cnt <= CNT_W'(HOLDOFF);
            end
            if (w_emit) begin
                outval1 <= r_sh1[w_sel];
                outval2 <= r_sh2[w_sel];
                outsel  <= w_sel;
                r_ptr   <= w_sel + 3'd1;
            end
        end
    end

    assign pending = r_dirty;
    assign busy    = (r_dirty != 8'h00) || (r_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_out_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_feeder
// Purpose  : Directed self-checking bench for out_feeder (HOLDOFF 4 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_feeder;

    logic        clock = 1'b0;
    logic        reset, reset_b;
    logic        wr_en, wr_half, clr, clr_b;
    logic [2:0]  wr_slot;
    logic [15:0] wr_data;
    logic [15:0] outval1, outval2, outval1_b, outval2_b;
    logic [2:0]  outsel, outsel_b;
    logic        outdisplay, outdisplay_b, busy, busy_b;
    logic [7:0]  pending, pending_b;
    logic        wr_en_b   = 1'b0;
    logic [2:0]  wr_slot_b = 3'd0;
    logic        wr_half_b = 1'b0;
    logic [15:0] wr_data_b = 16'h0000;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    out_feeder #(.HOLDOFF(4), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .wr_en(wr_en), .wr_slot(wr_slot),
        .wr_half(wr_half), .wr_data(wr_data), .clr(clr),
        .outval1(outval1), .outval2(outval2), .outsel(outsel),
        .outdisplay(outdisplay), .pending(pending), .busy(busy)
    );

    out_feeder #(.HOLDOFF(0), .CNT_W(8)) dut_b (
        .clock(clock), .reset(reset_b), .wr_en(wr_en_b), .wr_slot(wr_slot_b),
        .wr_half(wr_half_b), .wr_data(wr_data_b), .clr(clr_b),
        .outval1(outval1_b), .outval2(outval2_b), .outsel(outsel_b),
        .outdisplay(outdisplay_b), .pending(pending_b), .busy(busy_b)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_wr(input logic [2:0] s, input logic h, input logic [15:0] d);
        wr_en = 1'b1; wr_slot = s; wr_half = h; wr_data = d;
    endtask

    task automatic test_reset;
        reset = 1'b1; reset_b = 1'b1; clr = 1'b0; clr_b = 1'b0;
        wr_en = 1'b0; wr_slot = 3'd0; wr_half = 1'b0; wr_data = 16'h0000;
        step(2);
        checks++;
        if ({outdisplay, outsel, outval1, outval2, pending, busy} !== 45'd0)
            $display("FAIL reset_state: got disp=%b sel=%0d v1=%h v2=%h pend=%h busy=%b, want all 0",
                     outdisplay, outsel, outval1, outval2, pending, busy);
        else passes++;
        reset = 1'b0; reset_b = 1'b0;
        step(1);
    endtask

    task automatic test_single_write;
        drive_wr(3'd3, 1'b0, 16'h1234);
        step(1);
        wr_en = 1'b0;
        checks++;
        if (pending !== 8'h08) $display("FAIL t1_pending: got %h want 08", pending);
        else passes++;
        step(1);
        checks++;
        if ({outdisplay, outsel, outval1, outval2} !== {1'b1, 3'd3, 16'h1234, 16'h0000})
            $display("FAIL t1_emit: got disp=%b sel=%0d v1=%h v2=%h want 1/3/1234/0000",
                     outdisplay, outsel, outval1, outval2);
        else passes++;
        checks++;
        if ({pending, busy} !== {8'h00, 1'b1}) $display("FAIL t1_after_emit: got pend=%h busy=%b want 00/1", pending, busy);
        else passes++;
        step(1);
        checks++;
        if (outdisplay !== 1'b0) $display("FAIL t1_one_pulse: got %b want 0", outdisplay);
        else passes++;
        for (int k = 0; k < 2; k++) begin
            step(1);
            checks++;
            if (busy !== 1'b1) $display("FAIL t1_busy_hold%0d: got %b want 1", k, busy);
            else passes++;
        end
        step(1);
        checks++;
        if (busy !== 1'b0) $display("FAIL t1_busy_fall: got %b want 0", busy);
        else passes++;
    endtask

    task automatic test_round_robin;
        drive_wr(3'd3, 1'b0, 16'h1234);
        step(1);
        wr_en = 1'b0;
        step(1);
        checks++;
        if ({outdisplay, outsel} !== {1'b1, 3'd3}) $display("FAIL t2_prime: got disp=%b sel=%0d want 1/3", outdisplay, outsel);
        else passes++;
        drive_wr(3'd1, 1'b0, 16'h0101); step(1);
        drive_wr(3'd5, 1'b0, 16'h0505); step(1);
        drive_wr(3'd6, 1'b0, 16'h0606); step(1);
        wr_en = 1'b0;
        checks++;
        if (pending !== 8'h62) $display("FAIL t2_pending: got %h want 62", pending);
        else passes++;
        step(2);
        checks++;
        if ({outdisplay, outsel, outval1, pending} !== {1'b1, 3'd5, 16'h0505, 8'h42})
            $display("FAIL t2_emit5: got disp=%b sel=%0d v1=%h pend=%h want 1/5/0505/42", outdisplay, outsel, outval1, pending);
        else passes++;
        step(1);
        checks++;
        if ({outdisplay, outsel} !== {1'b0, 3'd5}) $display("FAIL t2_hold5: got disp=%b sel=%0d want 0/5", outdisplay, outsel);
        else passes++;
        step(4);
        checks++;
        if ({outdisplay, outsel, outval1, pending} !== {1'b1, 3'd6, 16'h0606, 8'h02})
            $display("FAIL t2_emit6: got disp=%b sel=%0d v1=%h pend=%h want 1/6/0606/02", outdisplay, outsel, outval1, pending);
        else passes++;
        step(5);
        checks++;
        if ({outdisplay, outsel, outval1, pending} !== {1'b1, 3'd1, 16'h0101, 8'h00})
            $display("FAIL t2_emit1: got disp=%b sel=%0d v1=%h pend=%h want 1/1/0101/00", outdisplay, outsel, outval1, pending);
        else passes++;
    endtask

    task automatic test_write_during_emit;
        step(4);
        drive_wr(3'd2, 1'b1, 16'hBEEF);
        step(1);
        drive_wr(3'd2, 1'b1, 16'hCAFE);
        step(1);
        wr_en = 1'b0;
        checks++;
        if ({outdisplay, outsel, outval1, outval2, pending} !== {1'b1, 3'd2, 16'h0000, 16'hBEEF, 8'h04})
            $display("FAIL t3_first: got disp=%b sel=%0d v1=%h v2=%h pend=%h want 1/2/0000/beef/04",
                     outdisplay, outsel, outval1, outval2, pending);
        else passes++;
        step(5);
        checks++;
        if ({outdisplay, outsel, outval2, pending} !== {1'b1, 3'd2, 16'hCAFE, 8'h00})
            $display("FAIL t3_second: got disp=%b sel=%0d v2=%h pend=%h want 1/2/cafe/00", outdisplay, outsel, outval2, pending);
        else passes++;
    endtask

    task automatic test_clear;
        step(4);
        drive_wr(3'd5, 1'b0, 16'h5555);
        step(1);
        wr_en = 1'b0;
        step(1);
        checks++;
        if ({outdisplay, outsel, outval1} !== {1'b1, 3'd5, 16'h5555})
            $display("FAIL t4_prime: got disp=%b sel=%0d v1=%h want 1/5/5555", outdisplay, outsel, outval1);
        else passes++;
        drive_wr(3'd0, 1'b0, 16'hAAAA); step(1);
        drive_wr(3'd7, 1'b1, 16'h7777); step(1);
        drive_wr(3'd3, 1'b0, 16'h3333); clr = 1'b1; step(1);
        wr_en = 1'b0; clr = 1'b0;
        checks++;
        if (pending !== 8'hFF) $display("FAIL t4_pending: got %h want ff", pending);
        else passes++;
        step(2);
        for (int k = 0; k < 8; k++) begin
            checks++;
            if ({outdisplay, outsel, outval1, outval2} !== {1'b1, 3'((6 + k) % 8), 32'h0})
                $display("FAIL t4_emit%0d: got disp=%b sel=%0d v1=%h v2=%h want 1/%0d/0000/0000",
                         k, outdisplay, outsel, outval1, outval2, (6 + k) % 8);
            else passes++;
            if (k < 7) step(5);
        end
        checks++;
        if (pending !== 8'h00) $display("FAIL t4_drained: got %h want 00", pending);
        else passes++;
    endtask

    task automatic test_back_to_back;
        clr_b = 1'b1;
        step(1);
        clr_b = 1'b0;
        checks++;
        if ({pending_b, busy_b} !== {8'hFF, 1'b1}) $display("FAIL t5_clr: got pend=%h busy=%b want ff/1", pending_b, busy_b);
        else passes++;
        for (int k = 0; k < 8; k++) begin
            step(1);
            checks++;
            if ({outdisplay_b, outsel_b, outval1_b} !== {1'b1, 3'(k), 16'h0000})
                $display("FAIL t5_pulse%0d: got disp=%b sel=%0d v1=%h want 1/%0d/0000", k, outdisplay_b, outsel_b, outval1_b, k);
            else passes++;
            if (k == 6) begin
                checks++;
                if (busy_b !== 1'b1) $display("FAIL t5_busy_mid: got %b want 1", busy_b);
                else passes++;
            end
        end
        checks++;
        if (busy_b !== 1'b0) $display("FAIL t5_busy_fall: got %b want 0", busy_b);
        else passes++;
        step(1);
        checks++;
        if (outdisplay_b !== 1'b0) $display("FAIL t5_end: got %b want 0", outdisplay_b);
        else passes++;
    endtask

    task automatic test_reset_mid_hold;
        logic seen;
        step(4);
        drive_wr(3'd3, 1'b0, 16'h3C3C); step(1);
        drive_wr(3'd4, 1'b0, 16'h4444); step(1);
        drive_wr(3'd5, 1'b0, 16'h5A5A); step(1);
        wr_en = 1'b0;
        checks++;
        if ({pending, outsel, outval1, busy} !== {8'h30, 3'd3, 16'h3C3C, 1'b1})
            $display("FAIL t6_setup: got pend=%h sel=%0d v1=%h busy=%b want 30/3/3c3c/1", pending, outsel, outval1, busy);
        else passes++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({outdisplay, outsel, outval1, outval2, pending, busy} !== 45'd0)
            $display("FAIL t6_async: got disp=%b sel=%0d v1=%h v2=%h pend=%h busy=%b want all 0",
                     outdisplay, outsel, outval1, outval2, pending, busy);
        else passes++;
        step(1);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (outdisplay) seen = 1'b1;
        end
        checks++;
        if ({seen, pending, busy} !== {1'b0, 8'h00, 1'b0})
            $display("FAIL t6_quiet: got pulse_seen=%b pend=%h busy=%b want 0/00/0", seen, pending, busy);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_write_during_emit();
        test_clear();
        test_back_to_back();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
